// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage single-precision compare/select unit (FEQ/FLT/FLE/FMIN/FMAX)
// behind a valid/ready handshake; the whole pipe stalls together on output backpressure.
module fcmp_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      op1,
  input  logic [31:0]      op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [2:0] OP_FEQ  = 3'd0;
  localparam logic [2:0] OP_FLT  = 3'd1;
  localparam logic [2:0] OP_FLE  = 3'd2;
  localparam logic [2:0] OP_FMIN = 3'd3;
  localparam logic [2:0] OP_FMAX = 3'd4;

  // Sign-magnitude less-than with flushed zeros; gt reuses it with swapped arguments.
  function automatic logic fp_lt(input logic sign_a, input logic sign_b,
                                 input logic both_zero, input logic mag_lt,
                                 input logic mag_eq);
    logic r;
    if (both_zero) begin
      r = 1'b0;
    end else if (sign_a != sign_b) begin
      r = sign_a;
    end else if (!sign_a) begin
      r = mag_lt;
    end else begin
      r = !mag_lt && !mag_eq;
    end
    return r;
  endfunction

  logic             advance_s;

  logic             s1_valid_q,  s1_valid_d;
  logic [2:0]       s1_op_q,     s1_op_d;
  logic [TAG_W-1:0] s1_tag_q,    s1_tag_d;
  logic [31:0]      s1_op1_q,    s1_op1_d;
  logic [31:0]      s1_op2_q,    s1_op2_d;
  logic             s1_mag_lt_q, s1_mag_lt_d;
  logic             s1_mag_eq_q, s1_mag_eq_d;
  logic             s1_z1_q,     s1_z1_d;
  logic             s1_z2_q,     s1_z2_d;

  logic             out_valid_q,   out_valid_d;
  logic [31:0]      out_data_q,    out_data_d;
  logic [TAG_W-1:0] out_tag_q,     out_tag_d;
  logic             out_illegal_q, out_illegal_d;

  logic             both_zero_s;
  logic             eq_s;
  logic             lt_s;
  logic             gt_s;
  logic [31:0]      res_data_s;
  logic             res_ill_s;

  // Handshake: the pipe moves only when the output slot is free or being drained.
  always_comb begin
    advance_s = !out_valid_q || out_ready;
    in_ready  = advance_s && !rst;
  end

  // Stage 1: capture request and do the single magnitude comparison.
  always_comb begin
    if (advance_s) begin
      s1_valid_d  = in_valid;
      s1_op_d     = in_op;
      s1_tag_d    = in_tag;
      s1_op1_d    = op1;
      s1_op2_d    = op2;
      s1_mag_lt_d = op1[30:0] <  op2[30:0];
      s1_mag_eq_d = op1[30:0] == op2[30:0];
      s1_z1_d     = op1[30:23] == 8'd0;
      s1_z2_d     = op2[30:23] == 8'd0;
    end else begin
      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_tag_d    = s1_tag_q;
      s1_op1_d    = s1_op1_q;
      s1_op2_d    = s1_op2_q;
      s1_mag_lt_d = s1_mag_lt_q;
      s1_mag_eq_d = s1_mag_eq_q;
      s1_z1_d     = s1_z1_q;
      s1_z2_d     = s1_z2_q;
    end
  end

  // Stage 2: sign resolution and result select.
  always_comb begin
    both_zero_s = s1_z1_q && s1_z2_q;
    eq_s        = both_zero_s || (s1_op1_q == s1_op2_q);
    lt_s        = fp_lt(s1_op1_q[31], s1_op2_q[31], both_zero_s, s1_mag_lt_q, s1_mag_eq_q);
    // b < a in magnitude is exactly "neither a < b nor a == b".
    gt_s        = fp_lt(s1_op2_q[31], s1_op1_q[31], both_zero_s,
                        !s1_mag_lt_q && !s1_mag_eq_q, s1_mag_eq_q);
    res_data_s  = 32'd0;
    res_ill_s   = 1'b0;
    case (s1_op_q)
      OP_FEQ:  res_data_s = {31'd0, eq_s};
      OP_FLT:  res_data_s = {31'd0, lt_s};
      OP_FLE:  res_data_s = {31'd0, lt_s || eq_s};
      OP_FMIN: res_data_s = gt_s ? s1_op2_q : s1_op1_q;
      OP_FMAX: res_data_s = lt_s ? s1_op2_q : s1_op1_q;
      default: begin
        res_data_s = 32'd0;
        res_ill_s  = 1'b1;
      end
    endcase
  end

  // Output slot: load stage-2 result on advance, otherwise hold it stable.
  always_comb begin
    if (advance_s) begin
      out_valid_d   = s1_valid_q;
      out_data_d    = res_data_s;
      out_tag_d     = s1_tag_q;
      out_illegal_d = res_ill_s;
    end else begin
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_tag_d     = out_tag_q;
      out_illegal_d = out_illegal_q;
    end
  end

  // Pipeline registers with synchronous reset; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_op_q       <= 3'd0;
      s1_tag_q      <= {TAG_W{1'b0}};
      s1_op1_q      <= 32'd0;
      s1_op2_q      <= 32'd0;
      s1_mag_lt_q   <= 1'b0;
      s1_mag_eq_q   <= 1'b0;
      s1_z1_q       <= 1'b0;
      s1_z2_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 32'd0;
      out_tag_q     <= {TAG_W{1'b0}};
      out_illegal_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_op_q       <= s1_op_d;
      s1_tag_q      <= s1_tag_d;
      s1_op1_q      <= s1_op1_d;
      s1_op2_q      <= s1_op2_d;
      s1_mag_lt_q   <= s1_mag_lt_d;
      s1_mag_eq_q   <= s1_mag_eq_d;
      s1_z1_q       <= s1_z1_d;
      s1_z2_q       <= s1_z2_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_tag_q     <= out_tag_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_illegal_q;

endmodule
